// File: rtl/coverage_toggle_collector_if.sv
// Drain stream of the toggle collector: one (index, count, seen) beat per
// accepted valid/ready handshake.
interface coverage_toggle_collector_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] out_count;
  logic             out_seen;

  modport master (output out_valid, out_idx, out_count, out_seen, input out_ready);
  modport slave  (input out_valid, out_idx, out_count, out_seen, output out_ready);
endinterface

// File: rtl/coverage_toggle_collector.sv
// Per-bit saturating toggle counters over an observed state vector.
// COLLECT samples the vector, DRAIN streams (idx, count, seen) beats,
// DONE holds the results for readback until clear.
module coverage_toggle_collector #(
  parameter int WIDTH     = 64,
  parameter int CNT_W     = 8,
  parameter int TOTAL_W   = 32,
  parameter int SKIP_ZERO = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clear,
  input  logic                         finish,
  input  logic [WIDTH-1:0]             state,
  coverage_toggle_collector_if.master  drain,
  output logic [TOTAL_W-1:0]           total_toggles,
  output logic [$clog2(WIDTH+1)-1:0]   covered_bits,
  output logic                         busy,
  output logic                         done
);
  localparam int IDX_W  = $clog2(WIDTH);
  localparam int CW_W   = $clog2(WIDTH+1);
  localparam int TSUM_W = TOTAL_W + 1;

  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} fsm_t;

  fsm_t                        fsm, fsm_nxt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0]            seen, seen_nxt;
  logic [WIDTH-1:0]            prev_state, prev_nxt;
  logic                        prev_valid, pv_nxt;
  logic [IDX_W-1:0]            idx, idx_nxt;
  logic [WIDTH-1:0]            tog;
  logic                        sample, zero_all, advance, last, valid_nxt;
  logic [CW_W-1:0]             pop_tog, pop_new, cov_nxt;
  logic [TSUM_W-1:0]           tsum;
  logic [TOTAL_W-1:0]          total_nxt;

  assign drain.out_idx = idx;
  assign last          = (idx == IDX_W'(WIDTH-1));
  // A beat held with out_valid=0 is a skipped zero-count index: always advance.
  assign advance       = drain.out_valid ? drain.out_ready : 1'b1;
  assign tog           = sample ? (state ^ prev_state) : '0;

  // Next-state and sampling control; clear beats finish in COLLECT.
  always_comb begin
    fsm_nxt  = fsm;
    idx_nxt  = idx;
    pv_nxt   = prev_valid;
    prev_nxt = prev_state;
    zero_all = 1'b0;
    sample   = 1'b0;
    unique case (fsm)
      S_COLLECT: begin
        if (clear) begin
          zero_all = 1'b1;
        end else begin
          if (en) begin
            // First enabled sample after reset/clear only primes prev_state.
            sample   = prev_valid;
            prev_nxt = state;
            pv_nxt   = 1'b1;
          end
          if (finish) begin
            fsm_nxt = S_DRAIN;
            idx_nxt = '0;
          end
        end
      end
      S_DRAIN: begin
        if (advance) begin
          if (last) fsm_nxt = S_DONE;
          else      idx_nxt = idx + 1'b1;
        end
      end
      S_DONE: begin
        if (clear) begin
          zero_all = 1'b1;
          fsm_nxt  = S_COLLECT;
        end
      end
      default: fsm_nxt = S_COLLECT;
    endcase
    if (zero_all) begin
      pv_nxt   = 1'b0;
      prev_nxt = '0;
      idx_nxt  = '0;
    end
  end

  // Per-bit saturating counters, sticky seen flags and the popcounts feeding
  // the global summaries.
  always_comb begin
    cnt_nxt  = cnt;
    seen_nxt = seen;
    pop_tog  = '0;
    pop_new  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_tog = pop_tog + CW_W'(tog[i]);
      pop_new = pop_new + CW_W'(tog[i] & ~seen[i]);
      if (zero_all) begin
        cnt_nxt[i]  = '0;
        seen_nxt[i] = 1'b0;
      end else if (tog[i]) begin
        if (cnt[i] != '1) cnt_nxt[i] = cnt[i] + 1'b1;
        seen_nxt[i] = 1'b1;
      end
    end
  end

  // Saturating total and covered-bit count.
  always_comb begin
    tsum      = {1'b0, total_toggles} + TSUM_W'(pop_tog);
    total_nxt = tsum[TOTAL_W] ? '1 : tsum[TOTAL_W-1:0];
    cov_nxt   = covered_bits + pop_new;
    if (zero_all) begin
      total_nxt = '0;
      cov_nxt   = '0;
    end
    // Payload is registered from next-cycle values so it lines up with out_valid.
    valid_nxt = (fsm_nxt == S_DRAIN) &&
                !((SKIP_ZERO != 0) && (cnt_nxt[idx_nxt] == '0));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm             <= S_COLLECT;
      cnt             <= '0;
      seen            <= '0;
      prev_state      <= '0;
      prev_valid      <= 1'b0;
      idx             <= '0;
      total_toggles   <= '0;
      covered_bits    <= '0;
      drain.out_valid <= 1'b0;
      drain.out_count <= '0;
      drain.out_seen  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      fsm             <= fsm_nxt;
      cnt             <= cnt_nxt;
      seen            <= seen_nxt;
      prev_state      <= prev_nxt;
      prev_valid      <= pv_nxt;
      idx             <= idx_nxt;
      total_toggles   <= total_nxt;
      covered_bits    <= cov_nxt;
      drain.out_valid <= valid_nxt;
      drain.out_count <= cnt_nxt[idx_nxt];
      drain.out_seen  <= seen_nxt[idx_nxt];
      busy            <= (fsm_nxt == S_DRAIN);
      done            <= (fsm_nxt == S_DONE);
    end
  end
endmodule

// File: doc/coverage_toggle_collector.md
Name: coverage_toggle_collector

Overview:
- Synthesizable successor to the simulation-only toggle probe.
- Accumulates per-bit toggle counts of a WIDTH-bit observed state vector while the design runs. On `finish`, drains the results as (index, count, seen) beats over a valid/ready stream.
- Sits beside the DUT top level in the ASIC testbench and FPGA builds. It replaces per-cycle file dumps with on-chip counters.

Parameters:
- WIDTH, 64, width of the observed state vector; must be >= 2.
- CNT_W, 8, width of each per-bit saturating toggle counter.
- TOTAL_W, 32, width of the saturating global toggle total.
- SKIP_ZERO, 0, when 1 the drain suppresses beats for bits whose count is 0.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample enable; state is compared only on cycles with en=1.
- clear  in  1  zero all counters and re-arm; honoured only in COLLECT and DONE.
- finish  in  1  end of run; starts the drain.
- state  in  WIDTH  observed vector.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  drain beat accepted when out_valid and out_ready are both 1.
- out_idx  out  $clog2(WIDTH)  bit index of the beat.
- out_count  out  CNT_W  toggle count of that bit.
- out_seen  out  1  bit toggled at least once.
- total_toggles  out  TOTAL_W  saturating sum of all counted toggles.
- covered_bits  out  $clog2(WIDTH+1)  number of bits with seen=1.
- busy  out  1  in DRAIN.
- done  out  1  in DONE.

Behaviour:
- Reset: FSM enters COLLECT and all outputs go to 0.
  - Cleared state: counters, seen[], total_toggles, covered_bits, out_idx, prev_state, prev_valid.
- Toggle definition: toggle = state ^ prev_state, evaluated only when en=1 and prev_valid=1.
- First-sample rule:
  - After reset or clear, the first en=1 cycle only loads prev_state and sets prev_valid.
  - No toggles are counted on that cycle; reset zeros never produce spurious counts.
- en=0: prev_state, prev_valid and all counters hold.
- Per-bit counters: a bit whose toggle is 1 increments its counter by 1, saturating at 2^CNT_W-1.
- seen[i] sets on the first counted toggle of bit i and is sticky.
- total_toggles adds popcount(toggle) each counted cycle and saturates at 2^TOTAL_W-1.
- covered_bits adds popcount(toggle & ~seen) each counted cycle. All three update together, one cycle after the sampled edge.
- FSM COLLECT:
  - Sampling is active.
  - finish=1 moves to DRAIN next cycle with out_idx=0. The finish-cycle sample is still counted.
  - clear=1 zeroes all counters and prev_valid in place.
  - If clear and finish are asserted together, clear wins and the FSM stays in COLLECT.
- FSM DRAIN:
  - Sampling is frozen; busy=1.
  - Each beat presents out_idx, the counter value and seen[idx]. out_valid stays high and payload stays stable until accepted.
  - On acceptance, out_idx increments. Acceptance at idx=WIDTH-1 moves to DONE and out_valid drops the next cycle.
  - SKIP_ZERO=1: an index with count 0 is skipped at one index per cycle with out_valid=0. A skipped idx=WIDTH-1 also moves to DONE.
  - clear, finish and en are ignored in DRAIN.
- FSM DONE:
  - done=1; counters and summary outputs hold for readback.
  - clear returns to COLLECT with everything zeroed and done=0 the next cycle.
  - finish is ignored.
- reset at any time, including mid-drain, aborts immediately to the reset state. No partial beat is retained.
- Outputs are registered; out_count and out_seen are valid in the same cycle as out_valid.

Test Plan:
- Parameters WIDTH=8, CNT_W=4, SKIP_ZERO=0 unless stated.
- After reset, en=1, state=8'hFF then 8'h00 then 8'hFF -> every counter=2, total_toggles=16, covered_bits=8. The first sample (8'hFF) is not counted.
- Bit 0 toggled 20 times, bit 7 toggled 3 times, then finish with out_ready=1 -> 8 beats idx 0..7:
  - idx0 count=15 (saturated), seen=1.
  - idx7 count=3, seen=1.
  - All other bits count=0, seen=0.
  - Then done=1.
- Backpressure: during the drain, out_ready=0 for 5 cycles at idx=3 -> out_valid stays 1 and out_idx/out_count stay stable. The beat completes once ready returns, with no beat lost or duplicated.
- SKIP_ZERO=1, only bits 2 and 5 toggled once each -> exactly 2 beats (idx2 count=1, idx5 count=1), then done=1 within WIDTH+2 cycles of finish.
- en=0 for 10 cycles while state changes, then en=1 -> only the difference against the last enabled sample is counted. clear together with finish -> stays in COLLECT, counters zero.
- Reset asserted at drain beat idx=4 -> next cycle busy=0, out_valid=0, total_toggles=0. The next finish drains idx 0..7 with all counts 0.
